// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI tuning-code receiver.
package spi_pkg;

    localparam int VOICE_BITS_DEF = 8;
    localparam int CODE_BITS_DEF  = 32;
    localparam int FRAME_BITS     = VOICE_BITS_DEF + CODE_BITS_DEF;
    localparam int CNT_BITS       = 6;

    localparam logic [1:0] PS_UPDATE_DEF = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } rx_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, plus a third stage for edge detection.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], i_async};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {3{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_level = sync_q[1];
    assign o_rise  = sync_q[1] & ~sync_q[2];
    assign o_fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_tuning_rx.sv
// SPI slave receiving voice/tuning-code frames; releases one update strobe
// to the dds block only in the pipeline slot where its tuning RAM may be written.
module spi_tuning_rx
    import spi_pkg::*;
#(
    parameter int         VOICE_BITS = VOICE_BITS_DEF,
    parameter int         CODE_BITS  = CODE_BITS_DEF,
    parameter int         NUM_VOICES = 256,
    parameter logic [1:0] PS_UPDATE  = PS_UPDATE_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    input  logic [1:0]            i_pipeline_state,
    output logic                  o_SPI_flag,
    output logic [VOICE_BITS-1:0] o_SPI_voice_index,
    output logic [CODE_BITS-1:0]  o_SPI_tuning_code,
    output logic                  o_frame_error,
    output logic                  o_overrun
);

    localparam int                    FRAME_LEN = VOICE_BITS + CODE_BITS;
    localparam logic [CNT_BITS-1:0]   CNT_FULL  = CNT_BITS'(FRAME_LEN);
    localparam logic [CNT_BITS-1:0]   CNT_SAT   = CNT_BITS'(FRAME_LEN + 1);
    localparam logic [VOICE_BITS:0]   NUM_V     = (VOICE_BITS + 1)'(NUM_VOICES);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    // Pin order: 0 = sclk, 1 = cs_n, 2 = mosi. cs_n syncs reset to 0 so a
    // chip select already low at reset release is not mistaken for a frame start.
    logic [2:0] pin_async;
    logic [2:0] pin_level;
    logic [2:0] pin_rise;
    logic [2:0] pin_fall;

    assign pin_async = {i_mosi, i_cs_n, i_sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            spi_sync_edge #(
                .RESET_VAL (1'b0)
            ) u_sync (
                .i_clk   (i_clk),
                .i_rst_n (rst_n),
                .i_async (pin_async[gi]),
                .o_level (pin_level[gi]),
                .o_rise  (pin_rise[gi]),
                .o_fall  (pin_fall[gi])
            );
        end
    endgenerate

    logic sclk_rise;
    logic cs_start;
    logic cs_end;
    logic mosi_bit;
    logic unused_edges;

    assign sclk_rise    = pin_rise[0];
    assign cs_start     = pin_fall[1];
    assign cs_end       = pin_rise[1];
    assign mosi_bit     = pin_level[2];
    assign unused_edges = &{1'b0, pin_level[1:0], pin_fall[0], pin_rise[2], pin_fall[2]};

    rx_state_e               state_q,     state_d;
    logic [CNT_BITS-1:0]     count_q,     count_d;
    logic [FRAME_LEN-1:0]    shift_q,     shift_d;
    logic                    pend_q,      pend_d;
    logic [VOICE_BITS-1:0]   buf_idx_q,   buf_idx_d;
    logic [CODE_BITS-1:0]    buf_code_q,  buf_code_d;
    logic [VOICE_BITS-1:0]   out_idx_q,   out_idx_d;
    logic [CODE_BITS-1:0]    out_code_q,  out_code_d;

    logic                    deliver;
    logic                    commit_ok;
    logic                    frame_err;
    logic                    overrun;
    logic                    idx_bad;

    assign idx_bad = {1'b0, shift_q[FRAME_LEN-1 -: VOICE_BITS]} >= NUM_V;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        pend_d     = pend_q;
        buf_idx_d  = buf_idx_q;
        buf_code_d = buf_code_q;
        out_idx_d  = out_idx_q;
        out_code_d = out_code_q;
        commit_ok  = 1'b0;
        frame_err  = 1'b0;
        overrun    = 1'b0;
        deliver    = pend_q && (i_pipeline_state == PS_UPDATE);

        case (state_q)
            ST_IDLE: begin
                if (cs_start) begin
                    state_d = ST_SHIFT;
                    count_d = '0;
                end
            end
            ST_SHIFT: begin
                if (cs_end) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[FRAME_LEN-2:0], mosi_bit};
                    if (count_q != CNT_SAT) begin
                        count_d = count_q + CNT_BITS'(1);
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if ((count_q != CNT_FULL) || idx_bad) begin
                    frame_err = 1'b1;
                end else begin
                    commit_ok = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (deliver) begin
            out_idx_d  = buf_idx_q;
            out_code_d = buf_code_q;
            pend_d     = 1'b0;
        end

        // A commit in the delivery cycle refills the slot being emptied: no overrun.
        if (commit_ok) begin
            buf_idx_d  = shift_q[FRAME_LEN-1 -: VOICE_BITS];
            buf_code_d = shift_q[CODE_BITS-1:0];
            pend_d     = 1'b1;
            overrun    = pend_q && !deliver;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            shift_q    <= '0;
            pend_q     <= 1'b0;
            buf_idx_q  <= '0;
            buf_code_q <= '0;
            out_idx_q  <= '0;
            out_code_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            pend_q     <= pend_d;
            buf_idx_q  <= buf_idx_d;
            buf_code_q <= buf_code_d;
            out_idx_q  <= out_idx_d;
            out_code_q <= out_code_d;
        end
    end

    assign o_SPI_flag        = deliver;
    assign o_SPI_voice_index = deliver ? buf_idx_q  : out_idx_q;
    assign o_SPI_tuning_code = deliver ? buf_code_q : out_code_q;
    assign o_frame_error     = frame_err;
    assign o_overrun         = overrun;

endmodule

// File: tb/tb_spi_tuning_rx.sv
// Scoreboard bench for spi_tuning_rx: bit-banged SPI frames, free-running pipeline phase.
module tb_spi_tuning_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic [1:0]  ps;
    logic        flag;
    logic [7:0]  vidx;
    logic [31:0] code;
    logic        ferr;
    logic        ovr;

    always #5 clk = ~clk;

    spi_tuning_rx #(
        .VOICE_BITS (8),
        .CODE_BITS  (32),
        .NUM_VOICES (128),
        .PS_UPDATE  (2'd0)
    ) dut (
        .i_clk             (clk),
        .i_reset_n         (reset_n),
        .i_sclk            (sclk),
        .i_cs_n            (cs_n),
        .i_mosi            (mosi),
        .i_pipeline_state  (ps),
        .o_SPI_flag        (flag),
        .o_SPI_voice_index (vidx),
        .o_SPI_tuning_code (code),
        .o_frame_error     (ferr),
        .o_overrun         (ovr)
    );

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];
    bit          model_pending = 0;
    int          err_exp = 0, err_seen = 0;
    int          ovr_exp = 0, ovr_seen = 0;
    int          deliv_seen = 0;
    logic [39:0] last_exp = '0;
    logic [39:0] mon_e;
    bit          hold_ps = 0;
    logic [1:0]  hold_val = 2'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Reference model: a frame is accepted iff it has exactly 40 bits and index < 128;
    // an accepted frame replaces any still-undelivered one.
    task automatic model_frame(input int nbits, input logic [39:0] d);
        if (nbits != 40 || d[39:32] >= 8'd128) begin
            err_exp++;
        end else if (model_pending) begin
            ovr_exp++;
            exp_q[exp_q.size()-1] = d;
        end else begin
            exp_q.push_back(d);
            model_pending = 1;
        end
    endtask

    task automatic send_frame(input int nbits, input logic [39:0] d, input bit close);
        cs_n = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 40) ? d[39-i] : 1'($urandom_range(0, 1));
            wait_cyc(4);
            sclk = 1'b1;
            wait_cyc(4);
            sclk = 1'b0;
        end
        if (close) begin
            wait_cyc(4);
            model_frame(nbits, d);
            cs_n = 1'b1;
            $display("frame bits=%0d idx=%0h code=%0h", nbits, d[39:32], d[31:0]);
            wait_cyc(8);
        end
    endtask

    task automatic settle(input string name);
        wait_cyc(40);
        chk({name, "_frame_errors"}, err_seen, err_exp);
        chk({name, "_overruns"}, ovr_seen, ovr_exp);
        chk({name, "_undelivered"}, exp_q.size(), 0);
        chk({name, "_hold_idx"}, vidx, last_exp[39:32]);
        chk({name, "_hold_code"}, code, last_exp[31:0]);
    endtask

    // Pipeline phase: cycles 0,1,2 unless held.
    initial begin
        ps = 2'd0;
        forever begin
            @(posedge clk);
            #2;
            if (hold_ps) ps = hold_val;
            else         ps = (ps == 2'd2) ? 2'd0 : ps + 2'd1;
        end
    end

    // Monitor: pops the scoreboard on every update strobe.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (flag === 1'b1) begin
                chk("flag_slot", ps, 2'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_flag: got flag idx=%0h code=%0h, required no flag", vidx, code);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("deliver_idx", vidx, mon_e[39:32]);
                    chk("deliver_code", code, mon_e[31:0]);
                    last_exp = mon_e;
                end
                model_pending = 0;
                deliv_seen++;
                $display("deliver idx=%0h code=%0h ps=%0d", vidx, code, ps);
            end
            if (ferr === 1'b1) err_seen++;
            if (ovr === 1'b1)  ovr_seen++;
        end
    end

    int          deliv_before;
    logic [31:0] rnd_code;
    logic [7:0]  rnd_idx;
    int          rnd_bits;

    initial begin
        reset_n = 1'b1;
        sclk    = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        #2;
        reset_n = 1'b0;
        wait_cyc(3);
        chk("reset_flag", flag, 1'b0);
        chk("reset_ferr", ferr, 1'b0);
        chk("reset_ovr", ovr, 1'b0);
        chk("reset_idx", vidx, 8'h00);
        chk("reset_code", code, 32'h0);
        reset_n = 1'b1;
        wait_cyc(5);

        send_frame(40, {8'h05, 32'h0007A120}, 1);
        settle("basic");

        send_frame(39, {8'h11, 32'h12345678}, 1);
        send_frame(41, {8'h12, 32'h9ABCDEF0}, 1);
        settle("length");

        send_frame(40, {8'd200, 32'h0000BEEF}, 1);
        send_frame(40, {8'd127, 32'h00C0FFEE}, 1);
        settle("index_range");

        hold_ps  = 1;
        hold_val = 2'd1;
        wait_cyc(2);
        deliv_before = deliv_seen;
        send_frame(40, {8'd5, 32'd100}, 1);
        send_frame(40, {8'd6, 32'd200}, 1);
        wait_cyc(20);
        chk("held_no_delivery", deliv_seen - deliv_before, 0);
        chk("held_overrun", ovr_seen, ovr_exp);
        hold_ps = 0;
        settle("overrun");
        chk("overrun_single_delivery", deliv_seen - deliv_before, 1);

        send_frame(20, {8'd9, 32'h13572468}, 0);
        reset_n = 1'b0;
        #1;
        chk("async_reset_flag", flag, 1'b0);
        chk("async_reset_idx", vidx, 8'h00);
        chk("async_reset_code", code, 32'h0);
        chk("async_reset_ferr", ferr, 1'b0);
        exp_q.delete();
        model_pending = 0;
        last_exp      = '0;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(6);
        cs_n = 1'b1;
        sclk = 1'b0;
        wait_cyc(10);
        chk("aborted_no_error", err_seen, err_exp);
        send_frame(40, {8'd3, 32'd300000}, 1);
        settle("after_reset");

        cs_n = 1'b0;
        wait_cyc(10);
        model_frame(0, 40'h0);
        cs_n = 1'b1;
        wait_cyc(10);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b1;
            wait_cyc(4);
            sclk = 1'b0;
            wait_cyc(4);
        end
        settle("cs_glitch");

        for (int i = 0; i < 10; i++) begin
            rnd_idx  = 8'($urandom_range(0, 255));
            rnd_code = $urandom;
            case ($urandom_range(0, 5))
                0:       rnd_bits = 39;
                1:       rnd_bits = 41;
                default: rnd_bits = 40;
            endcase
            send_frame(rnd_bits, {rnd_idx, rnd_code}, 1);
        end
        settle("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
